// File: rtl/halt_pkg.sv
// -----------------------------------------------------------------------------
// halt_pkg
// Shared definitions for the halt_monitor retirement monitor:
//   - state_t     : monitor state (RUN / DRAIN / HALTED)
//   - REG_IDX_W   : architectural register-index width
//   - DATA_W      : register data width
//   - RETIRED_SAT : value at which the retired-instruction count saturates
// -----------------------------------------------------------------------------
package halt_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [DATA_W-1:0] RETIRED_SAT = '1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage : halt_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Parameters:
//   WIDTH    counter width
// Ports:
//   clk      in   clock, counts on rising edge
//   rst_n    in   asynchronous active-low clear
//   i_inc    in   increment enable
//   o_count  out  current (registered) count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs; blocking here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule : sat_counter

// File: rtl/halt_monitor.sv
// -----------------------------------------------------------------------------
// halt_monitor
// Simulation-side retirement monitor. Watches writeback, shadows the
// return-value register, counts retired instructions (saturating), and after a
// halt retires waits out a drain window plus any pending stores before raising
// a sticky isHalt. Pure observer: it never back-pressures the pipeline.
//
// Build option: define HALT_TIMEOUT_EN to force HALTED (with timed_out=1) when
// stores are still pending after DRAIN_TIMEOUT cycles in DRAIN. Without it the
// monitor waits indefinitely and timed_out is tied low.
//
// Parameters:
//   RET_REG        register index holding the program return value (1..31)
//   DRAIN_CYCLES   minimum cycles spent in DRAIN (>= 1)
//   DRAIN_TIMEOUT  DRAIN cycle limit (only meaningful with HALT_TIMEOUT_EN)
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   wb_valid       instruction retires this cycle
//   wb_halt        retiring instruction is a halt
//   wb_we          retiring instruction writes a register
//   wb_waddr       destination register index
//   wb_wdata       write data
//   store_pending  memory system still holds uncommitted stores
//   isHalt         program finished (sticky until reset)
//   ret_val        shadow copy of RET_REG
//   retired        saturating retired-instruction count
//   timed_out      halt was forced by the drain timeout
// -----------------------------------------------------------------------------
module halt_monitor
  import halt_pkg::*;
#(
  parameter int RET_REG       = 1,
  parameter int DRAIN_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic                 wb_halt,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0]    wb_wdata,
  input  logic                 store_pending,
  output logic                 isHalt,
  output logic [DATA_W-1:0]    ret_val,
  output logic [DATA_W-1:0]    retired,
  output logic                 timed_out
);

  // Reject configurations the monitor cannot honour at elaboration time.
  if (RET_REG < 1 || RET_REG > 31 || DRAIN_CYCLES < 1 ||
      DRAIN_TIMEOUT < DRAIN_CYCLES) begin : g_bad_param
    $error("halt_monitor: illegal parameter combination");
  end

`ifdef HALT_TIMEOUT_EN
  localparam int CNT_W = 32;
`else
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
`endif

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DRAIN_CYCLES - 1);
`ifdef HALT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(DRAIN_TIMEOUT - 1);
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [DATA_W-1:0] r_ret_val;
  logic             r_is_halt;
  logic             w_in_run;
  logic             w_retire;
  logic             w_ret_write;
  logic             w_drain_done;

  assign w_in_run     = (r_state == RUN);
  assign w_retire     = w_in_run && wb_valid;
  assign w_ret_write  = wb_valid && wb_we && (wb_waddr == REG_IDX_W'(RET_REG));
  assign w_drain_done = (r_drain_cnt >= CNT_DONE);

  sat_counter #(
    .WIDTH (DATA_W)
  ) u_retired (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_retire),
    .o_count (retired)
  );

`ifdef HALT_TIMEOUT_EN
  logic r_timed_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_ret_val   <= '0;
      r_is_halt   <= 1'b0;
`ifdef HALT_TIMEOUT_EN
      r_timed_out <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          // A write carried by the halt itself still lands on this edge.
          if (w_ret_write) begin
            r_ret_val <= wb_wdata;
          end
          if (wb_valid && wb_halt) begin
            r_state     <= DRAIN;
            r_drain_cnt <= '0;
          end
        end

        DRAIN: begin
          if (w_drain_done && !store_pending) begin
            r_state   <= HALTED;
            r_is_halt <= 1'b1;
`ifdef HALT_TIMEOUT_EN
          end else if (store_pending && r_drain_cnt >= CNT_TIMEOUT) begin
            r_state     <= HALTED;
            r_is_halt   <= 1'b1;
            r_timed_out <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          end
`else
          end else if (!w_drain_done) begin
            // Counter holds once satisfied so the narrow width cannot wrap
            // while waiting on stores.
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          end
`endif
        end

        HALTED: ;

        default: r_state <= RUN;
      endcase
    end
  end

  assign isHalt  = r_is_halt;
  assign ret_val = r_ret_val;
`ifdef HALT_TIMEOUT_EN
  assign timed_out = r_timed_out;
`else
  assign timed_out = 1'b0;
`endif

endmodule : halt_monitor

// File: tb/tb_halt_monitor.sv
// -----------------------------------------------------------------------------
// tb_halt_monitor
// Self-checking bench for halt_monitor (RET_REG=1, DRAIN_CYCLES=4,
// DRAIN_TIMEOUT=16) plus a narrow sat_counter instance for saturation.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_halt_monitor;

  localparam int RET_REG       = 1;
  localparam int DRAIN_CYCLES  = 4;
  localparam int DRAIN_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_halt = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        store_pending = 1'b0;
  logic        isHalt;
  logic [31:0] ret_val;
  logic [31:0] retired;
  logic        timed_out;

  logic        sc_rst_n = 1'b0;
  logic        sc_inc = 1'b0;
  logic [2:0]  sc_count;

  always #5 clk = ~clk;

  halt_monitor #(
    .RET_REG       (RET_REG),
    .DRAIN_CYCLES  (DRAIN_CYCLES),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_valid      (wb_valid),
    .wb_halt       (wb_halt),
    .wb_we         (wb_we),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .store_pending (store_pending),
    .isHalt        (isHalt),
    .ret_val       (ret_val),
    .retired       (retired),
    .timed_out     (timed_out)
  );

  sat_counter #(.WIDTH(3)) u_sc (
    .clk     (clk),
    .rst_n   (sc_rst_n),
    .i_inc   (sc_inc),
    .o_count (sc_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the edge at which the halt retired and decides
  // completion from elapsed edges and the store_pending seen before each edge.
  // ---------------------------------------------------------------------------
  int          edge_no;
  int          halt_edge;
  bit          m_done;
  bit          m_timed;
  logic [31:0] m_retired;
  logic [31:0] m_shadow;

  task automatic model_reset();
    edge_no   = 0;
    halt_edge = -1;
    m_done    = 1'b0;
    m_timed   = 1'b0;
    m_retired = '0;
    m_shadow  = '0;
  endtask

  task automatic model_edge(input bit v, input bit h, input bit we,
                            input logic [4:0] a, input logic [31:0] d, input bit sp);
    edge_no++;
    if (halt_edge < 0) begin
      if (v) begin
        if (m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 32'd1;
        if (we && a == 5'(RET_REG)) m_shadow = d;
        if (h) halt_edge = edge_no;
      end
    end else if (!m_done) begin
      if (edge_no - halt_edge >= DRAIN_CYCLES && !sp) m_done = 1'b1;
`ifdef HALT_TIMEOUT_EN
      else if (edge_no - halt_edge >= DRAIN_TIMEOUT && sp) begin
        m_done  = 1'b1;
        m_timed = 1'b1;
      end
`endif
    end
  endtask

  // Called at a falling edge: drive, cross one rising edge, return at next fall.
  task automatic drive_edge(input bit v, input bit h, input bit we,
                            input logic [4:0] a, input logic [31:0] d, input bit sp);
    wb_valid      = v;
    wb_halt       = h;
    wb_we         = we;
    wb_waddr      = a;
    wb_wdata      = d;
    store_pending = sp;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input bit v, input bit h, input bit we,
                      input logic [4:0] a, input logic [31:0] d, input bit sp);
    drive_edge(v, h, we, a, d, sp);
    model_edge(v, h, we, a, d, sp);
    check({tag, ".isHalt"},    32'(isHalt),    32'(m_done));
    check({tag, ".ret_val"},   ret_val,        m_shadow);
    check({tag, ".retired"},   retired,        m_retired);
    check({tag, ".timed_out"}, 32'(timed_out), 32'(m_timed));
  endtask

  task automatic idle(input string tag, input int n, input bit sp);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, sp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_halt = 1'b0; wb_we = 1'b0; store_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          v, h, we;
    logic [4:0]  a;
    logic [31:0] d;
    bit          sp;
    bit          exp_halt;
    logic [31:0] exp_ret;
    logic [31:0] exp_retired;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // ---------------- directed table: 10 retires, r1<=0x2A, halt -------------
    tbl.push_back('{1, 0, 1, 5'd1, 32'h2A,   0, 0, 32'h2A, 32'd1});
    tbl.push_back('{1, 0, 1, 5'd2, 32'h55,   0, 0, 32'h2A, 32'd2});
    tbl.push_back('{1, 0, 1, 5'd0, 32'hDEAD, 0, 0, 32'h2A, 32'd3});
    tbl.push_back('{1, 0, 0, 5'd1, 32'h1234, 0, 0, 32'h2A, 32'd4});
    tbl.push_back('{0, 1, 1, 5'd1, 32'hBAD,  0, 0, 32'h2A, 32'd4});
    for (int i = 0; i < 6; i++)
      tbl.push_back('{1, 0, 0, 5'd0, 32'd0, 0, 0, 32'h2A, 32'(5 + i)});
    tbl.push_back('{1, 1, 0, 5'd0, 32'd0,    0, 0, 32'h2A, 32'd11});
    tbl.push_back('{1, 0, 1, 5'd1, 32'h99,   0, 0, 32'h2A, 32'd11});
    tbl.push_back('{0, 0, 0, 5'd0, 32'd0,    0, 0, 32'h2A, 32'd11});
    tbl.push_back('{0, 0, 0, 5'd0, 32'd0,    0, 0, 32'h2A, 32'd11});
    tbl.push_back('{0, 0, 0, 5'd0, 32'd0,    0, 1, 32'h2A, 32'd11});
    tbl.push_back('{1, 0, 1, 5'd1, 32'h77,   1, 1, 32'h2A, 32'd11});

    // ---------------- reset values ----------------
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.isHalt",    32'(isHalt),    32'd0);
    check("reset.ret_val",   ret_val,        32'd0);
    check("reset.retired",   retired,        32'd0);
    check("reset.timed_out", 32'(timed_out), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive_edge(tbl[i].v, tbl[i].h, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].sp);
      check($sformatf("tbl[%0d].isHalt", i),  32'(isHalt), 32'(tbl[i].exp_halt));
      check($sformatf("tbl[%0d].ret_val", i), ret_val,     tbl[i].exp_ret);
      check($sformatf("tbl[%0d].retired", i), retired,     tbl[i].exp_retired);
    end

    // ---------------- halt cycle carries r1 write; DRAIN write ignored -------
    do_reset();
    step("hwr", 1, 1, 1, 5'd1, 32'h7, 0);
    step("hwr", 1, 0, 1, 5'd1, 32'h99, 0);
    idle("hwr", 2, 1'b0);
    step("hwr", 0, 0, 0, 5'd0, 32'd0, 0);
    check("hwr.final_isHalt",  32'(isHalt), 32'd1);
    check("hwr.final_ret_val", ret_val,     32'd7);
    check("hwr.final_retired", retired,     32'd1);

    // ---------------- store_pending held high 20 cycles ----------------
    do_reset();
    step("sp", 1, 0, 1, 5'd1, 32'h11, 0);
    step("sp", 1, 1, 0, 5'd0, 32'd0, 0);
    idle("sp", 20, 1'b1);
    check("sp.not_early", 32'(isHalt), 32'd0);
    step("sp", 0, 0, 0, 5'd0, 32'd0, 0);
    check("sp.rise_after_drop", 32'(isHalt), 32'd1);

    // ---------------- asynchronous reset mid-DRAIN ----------------
    do_reset();
    step("rmid", 1, 0, 1, 5'd1, 32'h5, 0);
    step("rmid", 1, 1, 0, 5'd0, 32'd0, 0);
    idle("rmid", 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rmid.async.isHalt",  32'(isHalt), 32'd0);
    check("rmid.async.ret_val", ret_val,     32'd0);
    check("rmid.async.retired", retired,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle("rmid.post", 3, 1'b0);
    step("rmid.post", 1, 0, 1, 5'd1, 32'hC0DE, 0);
    step("rmid.post", 1, 0, 0, 5'd0, 32'd0, 0);
    step("rmid.post", 1, 1, 0, 5'd0, 32'd0, 0);
    idle("rmid.post", 4, 1'b0);
    check("rmid.post.isHalt",  32'(isHalt), 32'd1);
    check("rmid.post.ret_val", ret_val,     32'hC0DE);

    // ---------------- store_pending stuck high ----------------
    do_reset();
    step("stuck", 1, 1, 0, 5'd0, 32'd0, 0);
    idle("stuck", 1000, 1'b1);
`ifdef HALT_TIMEOUT_EN
    check("stuck.isHalt",    32'(isHalt),    32'd1);
    check("stuck.timed_out", 32'(timed_out), 32'd1);
`else
    check("stuck.isHalt",    32'(isHalt),    32'd0);
    check("stuck.timed_out", 32'(timed_out), 32'd0);
`endif

    // ---------------- randomized programs vs model ----------------
    for (int p = 0; p < 10; p++) begin
      do_reset();
      for (int c = 0; c < 400 && !m_done; c++) begin
        step($sformatf("rnd%0d", p),
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0,
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)),
             $urandom,
             $urandom_range(0, 9) < 4);
      end
      idle($sformatf("rnd%0d.tail", p), 3, 1'b0);
    end

    // ---------------- saturation of a narrow sat_counter ----------------
    @(negedge clk);
    sc_rst_n = 1'b1;
    begin
      int exp_cnt;
      exp_cnt = 0;
      for (int i = 0; i < 14; i++) begin
        sc_inc = (i % 4) != 3;
        @(posedge clk);
        if (sc_inc && exp_cnt < 7) exp_cnt++;
        @(negedge clk);
        check($sformatf("sat[%0d]", i), 32'(sc_count), 32'(exp_cnt));
      end
      sc_inc = 1'b0;
      sc_rst_n = 1'b0;
      #1;
      check("sat.clear", 32'(sc_count), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_halt_monitor
